td4_program_loader: RTL and testbench

- Program memory and loader stage directly upstream of the TD4 core.
- Owns the 16x8 instruction store: takes byte-serial program loads over a valid/ready handshake, and serves the core's instruction fetch (core A -> D).
- Holds the core in reset while a load is in progress, then releases it to run.

---
 rtl/td4_program_loader.sv | 128 ++++++++++++
 tb/tb_td4_program_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/td4_program_loader.sv
// td4_program_loader: 16x8 program store and byte-serial loader for the TD4 core.
// Holds the core in reset (CPU_CLR=0) while idle or loading, and serves
// combinational instruction fetch (A -> D) once running.
// Optional feature macro: TD4_LOADER_CHECKSUM_EN enables the CHECKSUM
// accumulator; without it CHECKSUM is tied to zero.
module td4_program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              LOAD_START,
    input  logic              RUN_START,
    input  logic              LOAD_VALID,
    input  logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_READY,
    output logic              LOAD_DONE,
    output logic              CPU_CLR,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] CHECKSUM
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    // Next-state, pointer and write-enable decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD_START) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (RUN_START) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (LOAD_VALID) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (ptr_q == '1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (LOAD_START) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Program store write; contents survive reset, a reset edge suppresses the write
    always_ff @(posedge CLK) begin
        if (CLR && wr_en) begin
            mem_q[ptr_q] <= LOAD_DATA;
        end
    end

    // State-decoded handshake, core reset and gated fetch
    always_comb begin
        LOAD_READY = (state_q == LOAD);
        CPU_CLR    = (state_q == RUN);
        LOAD_DONE  = done_q;
        D          = (state_q == RUN) ? mem_q[A] : '0;
    end

`ifdef TD4_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Checksum: cleared on entry to LOAD, accumulates each accepted byte
    always_comb begin
        csum_d = csum_q;
        if (state_q != LOAD && state_d == LOAD) begin
            csum_d = '0;
        end else if (wr_en) begin
            csum_d = csum_q + LOAD_DATA;
        end
    end

    // Checksum register
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign CHECKSUM = csum_q;
`else
    assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_td4_program_loader.sv
// tb_td4_program_loader: self-checking bench for td4_program_loader.
// Expected fetch words are pushed to a scoreboard queue as each address is
// driven and popped when D is sampled.
module tb_td4_program_loader;

    logic       CLK;
    logic       CLR;
    logic       LOAD_START;
    logic       RUN_START;
    logic       LOAD_VALID;
    logic [7:0] LOAD_DATA;
    logic       LOAD_READY;
    logic       LOAD_DONE;
    logic       CPU_CLR;
    logic [3:0] A;
    logic [7:0] D;
    logic [7:0] CHECKSUM;

    td4_program_loader #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .LOAD_START(LOAD_START),
        .RUN_START (RUN_START),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_DATA (LOAD_DATA),
        .LOAD_READY(LOAD_READY),
        .LOAD_DONE (LOAD_DONE),
        .CPU_CLR   (CPU_CLR),
        .A         (A),
        .D         (D),
        .CHECKSUM  (CHECKSUM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] model_mem [0:15];
    logic [3:0] model_ptr;
    logic [7:0] model_csum;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] exp_csum();
`ifdef TD4_LOADER_CHECKSUM_EN
        return model_csum;
`else
        return 8'h00;
`endif
    endfunction

    // Pulse the start inputs for one cycle; model tracks entry into LOAD
    task automatic start(input logic ls, input logic rs);
        LOAD_START = ls;
        RUN_START  = rs;
        step();
        LOAD_START = 1'b0;
        RUN_START  = 1'b0;
        if (ls) begin
            model_ptr  = 4'd0;
            model_csum = 8'h00;
        end
    endtask

    // Feed n bytes; optional idle cycle before each, optional start pokes mid-load
    task automatic load_bytes(input int n, input logic [7:0] base, input bit incr,
                              input bit stall, input bit poke, output int cycles);
        logic [7:0] b;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            b = incr ? base + 8'(i) : base;
            if (stall) begin
                LOAD_VALID = 1'b0;
                if (poke && i == 8) begin
                    LOAD_START = 1'b1;
                    RUN_START  = 1'b1;
                end
                check("ready_stall", LOAD_READY, 1);
                step();
                LOAD_START = 1'b0;
                RUN_START  = 1'b0;
                cycles++;
            end
            LOAD_VALID = 1'b1;
            LOAD_DATA  = b;
            check("ready_xfer", LOAD_READY, 1);
            step();
            cycles++;
            model_mem[model_ptr] = b;
            model_ptr  = model_ptr + 4'd1;
            model_csum = model_csum + b;
        end
        LOAD_VALID = 1'b0;
    endtask

    // Completion of a full 16-byte load
    task automatic check_done();
        check("done_pulse", LOAD_DONE, 1);
        check("cpu_clr_run", CPU_CLR, 1);
        check("ready_off", LOAD_READY, 0);
        check("csum_done", CHECKSUM, exp_csum());
        step();
        check("done_clear", LOAD_DONE, 0);
        check("cpu_clr_hold", CPU_CLR, 1);
    endtask

    // Fetch every address through the scoreboard
    task automatic fetch_all();
        for (int a = 0; a < 16; a++) begin
            A = 4'(a);
            exp_q.push_back(model_mem[a]);
            #1;
            check("fetch", D, exp_q.pop_front());
        end
    endtask

    int cyc;

    initial begin
        CLR        = 1'b0;
        LOAD_START = 1'b0;
        RUN_START  = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = 8'h00;
        A          = 4'h0;
        model_ptr  = 4'd0;
        model_csum = 8'h00;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        // Reset state
        step();
        step();
        CLR = 1'b1;
        check("rst_ready", LOAD_READY, 0);
        check("rst_cpu_clr", CPU_CLR, 0);
        check("rst_done", LOAD_DONE, 0);
        check("rst_csum", CHECKSUM, 0);
        A = 4'h3;
        #1;
        check("idle_d_zero", D, 0);

        // Full load 0x00..0x0F back to back
        start(1'b1, 1'b0);
        check("load_entry", LOAD_READY, 1);
        A = 4'h7;
        #1;
        check("load_d_zero", D, 0);
        load_bytes(16, 8'h00, 1'b1, 1'b0, 1'b0, cyc);
        check("full_cycles", cyc, 16);
        check_done();
        A = 4'h7;
        #1;
        check("fetch_a7", D, 8'h07);
        fetch_all();

        // Reload from RUN with stalls on alternate cycles and ignored start pokes
        start(1'b1, 1'b0);
        check("reload_cpu_clr", CPU_CLR, 0);
        check("reload_ready", LOAD_READY, 1);
        load_bytes(16, 8'h20, 1'b1, 1'b1, 1'b1, cyc);
        check("stall_cycles", cyc, 32);
        check_done();
        fetch_all();

        // Reset from RUN, then priority: both starts in IDLE -> LOAD
        CLR = 1'b0;
        step();
        CLR = 1'b1;
        model_csum = 8'h00;
        check("run_rst_cpu_clr", CPU_CLR, 0);
        check("run_rst_csum", CHECKSUM, 0);
        start(1'b1, 1'b1);
        check("prio_load", LOAD_READY, 1);
        check("prio_cpu_clr", CPU_CLR, 0);

        // Reset mid-load after 5 bytes
        load_bytes(5, 8'hA0, 1'b1, 1'b0, 1'b0, cyc);
        check("partial_ready", LOAD_READY, 1);
        check("partial_done", LOAD_DONE, 0);
        CLR = 1'b0;
        step();
        CLR = 1'b1;
        model_csum = 8'h00;
        check("mid_rst_ready", LOAD_READY, 0);
        check("mid_rst_cpu_clr", CPU_CLR, 0);
        check("mid_rst_done", LOAD_DONE, 0);
        check("mid_rst_csum", CHECKSUM, 0);
        A = 4'h3;
        #1;
        check("idle_gate_a3", D, 0);
        start(1'b0, 1'b1);
        check("run_start", CPU_CLR, 1);
        check("run_ready", LOAD_READY, 0);
        check("run_csum_hold", CHECKSUM, exp_csum());
        fetch_all();

        // Reload from RUN with 16 bytes of 0xB0
        start(1'b1, 1'b0);
        check("b0_cpu_clr", CPU_CLR, 0);
        load_bytes(16, 8'hB0, 1'b0, 1'b0, 1'b0, cyc);
        check_done();
        fetch_all();

        // Checksum load: 16 x 0x11
        start(1'b1, 1'b0);
        load_bytes(16, 8'h11, 1'b0, 1'b0, 1'b0, cyc);
        check_done();
`ifdef TD4_LOADER_CHECKSUM_EN
        check("csum_0x11", CHECKSUM, 8'h10);
`else
        check("csum_tied", CHECKSUM, 8'h00);
`endif
        fetch_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
